// File: rtl/pwm_pkg.sv
// pwm_pkg: shared output-state encoding and counter width for the PWM driver.
package pwm_pkg;
    localparam int CNT_W = 8;
    typedef enum logic [1:0] {OFF, LOW, HIGH, DEAD} pwm_state_e;
endpackage

// File: rtl/pwm_deadtime.sv
// pwm_deadtime: complementary output FSM inserting DEADTIME idle ticks before either side turns on.
module pwm_deadtime import pwm_pkg::*; #(
    parameter int DEADTIME = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    input  logic tick,
    input  logic enable,
    output logic pwm_h,
    output logic pwm_l
);
    localparam logic [3:0] DT_LAST = 4'(DEADTIME - 1);
    pwm_state_e state_q;
    logic [3:0] dcnt_q;
    logic       pwm_h_q;
    logic       pwm_l_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= OFF;
            dcnt_q  <= '0;
            pwm_h_q <= 1'b0;
            pwm_l_q <= 1'b0;
        end else if (!enable) begin
            state_q <= OFF;
            dcnt_q  <= '0;
            pwm_h_q <= 1'b0;
            pwm_l_q <= 1'b0;
        end else if (tick) begin
            case (state_q)
                OFF: begin
                    state_q <= DEAD;
                    dcnt_q  <= '0;
                end
                LOW: if (raw) begin
                    state_q <= DEAD;
                    dcnt_q  <= '0;
                    pwm_l_q <= 1'b0;
                end
                HIGH: if (!raw) begin
                    state_q <= DEAD;
                    dcnt_q  <= '0;
                    pwm_h_q <= 1'b0;
                end
                DEAD: if (dcnt_q == DT_LAST) begin
                    // raw is sampled only at the end of the dead window, so short glitches are swallowed
                    state_q <= raw ? HIGH : LOW;
                    pwm_h_q <= raw;
                    pwm_l_q <= !raw;
                end else begin
                    dcnt_q <= dcnt_q + 4'd1;
                end
            endcase
        end
    end
    assign pwm_h = pwm_h_q;
    assign pwm_l = pwm_l_q;
endmodule

// File: rtl/pwm_driver.sv
// pwm_driver: prescaled 256-tick PWM with double-buffered duty, period-start strobe and dead-time outputs.
module pwm_driver import pwm_pkg::*; #(
    parameter int PRESCALE = 4,
    parameter int DEADTIME = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [CNT_W-1:0] duty_in,
    input  logic             duty_valid,
    output logic             duty_ready,
    output logic             pwm_h,
    output logic             pwm_l,
    output logic             period_start,
    output logic [CNT_W-1:0] duty_active
);
    localparam logic [CNT_W-1:0] PSC_LAST = CNT_W'(PRESCALE - 1);
    logic [CNT_W-1:0] presc_q, presc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] duty_active_q, duty_active_d;
    logic [CNT_W-1:0] pending_q, pending_d;
    logic             pending_full_q, pending_full_d;
    logic             period_start_q, period_start_d;
    logic             tick, wrap, accept, raw;
    always_comb begin
        tick           = enable && (presc_q == PSC_LAST);
        wrap           = tick && (&cnt_q);
        accept         = duty_valid && !pending_full_q;
        raw            = enable && (cnt_q < duty_active_q);
        presc_d        = (!enable || tick) ? '0 : presc_q + 1'b1;
        cnt_d          = !enable ? '0 : cnt_q + CNT_W'(tick);
        pending_d      = accept ? duty_in : pending_q;
        // a full slot blocks accept, so a wrap never races a new capture
        pending_full_d = accept || (pending_full_q && !wrap);
        duty_active_d  = (wrap && pending_full_q) ? pending_q : duty_active_q;
        period_start_d = wrap;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q        <= '0;
            cnt_q          <= '0;
            duty_active_q  <= '0;
            pending_q      <= '0;
            pending_full_q <= 1'b0;
            period_start_q <= 1'b0;
        end else begin
            presc_q        <= presc_d;
            cnt_q          <= cnt_d;
            duty_active_q  <= duty_active_d;
            pending_q      <= pending_d;
            pending_full_q <= pending_full_d;
            period_start_q <= period_start_d;
        end
    end
    assign duty_ready   = !pending_full_q;
    assign period_start = period_start_q;
    assign duty_active  = duty_active_q;
    pwm_deadtime #(.DEADTIME(DEADTIME)) u_deadtime (
        .clk    (clk),
        .rst_n  (rst_n),
        .raw    (raw),
        .tick   (tick),
        .enable (enable),
        .pwm_h  (pwm_h),
        .pwm_l  (pwm_l)
    );
endmodule

// File: tb/tb_pwm_driver.sv
// tb_pwm_driver: scoreboard bench checking per-period duty and output timing against an arithmetic model.
module tb_pwm_driver;
    localparam int DT = 2;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic [7:0] duty_in = '0;
    logic       duty_valid = 1'b0;
    logic       duty_ready, pwm_h, pwm_l, period_start;
    logic [7:0] duty_active;
    logic       en4 = 1'b0;
    logic [7:0] duty4 = '0;
    logic       valid4 = 1'b0;
    logic       ready4, h4, l4, ps4;
    logic [7:0] active4;
    int tests = 0;
    int fails = 0;
    bit mon_on = 0;

    typedef struct packed {logic [7:0] duty; logic check;} rec_t;
    rec_t sb_q[$];
    rec_t cur;
    bit   win_open = 0;
    int   len, hc, lc, eh, el;
    logic [7:0] cur_duty = '0;

    always #5 clk = ~clk;

    pwm_driver #(.PRESCALE(1), .DEADTIME(DT)) u_dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .duty_in(duty_in), .duty_valid(duty_valid),
        .duty_ready(duty_ready), .pwm_h(pwm_h), .pwm_l(pwm_l), .period_start(period_start),
        .duty_active(duty_active)
    );
    pwm_driver #(.PRESCALE(4), .DEADTIME(DT)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .enable(en4), .duty_in(duty4), .duty_valid(valid4),
        .duty_ready(ready4), .pwm_h(h4), .pwm_l(l4), .period_start(ps4), .duty_active(active4)
    );

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Steady-state clk counts per 256-clk period at PRESCALE=1, from the dead-time rules
    function automatic void exp_counts(input int d, output int h, output int l);
        if (d == 0) begin h = 0; l = 256; end
        else if (d <= DT) begin h = 0; l = 256 - DT; end
        else if (d >= 256 - DT) begin h = 256 - DT; l = 0; end
        else begin h = d - DT; l = 256 - d - DT; end
    endfunction

    always @(negedge clk) begin
        if ((pwm_h && pwm_l) || (h4 && l4)) begin
            fails++;
            $display("FAIL overlap: pwm_h and pwm_l both high (t=%0t)", $time);
        end
    end

    always @(negedge clk) begin
        if (!mon_on) win_open = 0;
        else begin
            if (period_start) begin
                if (win_open) begin
                    chk("period_len", len, 256);
                    if (cur.check) begin
                        exp_counts(int'(cur.duty), eh, el);
                        chk($sformatf("h_clks duty=%0d", cur.duty), hc, eh);
                        chk($sformatf("l_clks duty=%0d", cur.duty), lc, el);
                    end
                end
                if (sb_q.size() == 0) chk("sb_underflow", 0, 1);
                else begin
                    cur = sb_q.pop_front();
                    chk("duty_active", int'(duty_active), int'(cur.duty));
                end
                win_open = 1;
                len = 0;
                hc = 0;
                lc = 0;
            end
            if (win_open) begin
                len++;
                hc += int'(pwm_h);
                lc += int'(pwm_l);
            end
        end
    end

    task automatic wait_ps();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!period_start && n < 600);
        if (!period_start) chk("period_start_timeout", 0, 1);
    endtask

    // Caller sits at a negedge; returns one negedge after the transfer
    task automatic hs(input logic [7:0] d, output int waited, output logic ps_at_acc);
        duty_in = d;
        duty_valid = 1'b1;
        waited = 0;
        while (!duty_ready && waited < 600) begin
            @(negedge clk);
            waited++;
        end
        ps_at_acc = period_start;
        if (!duty_ready) chk("handshake_timeout", 0, 1);
        @(negedge clk);
        duty_valid = 1'b0;
    endtask

    task automatic seg(input logic [7:0] d);
        int w;
        logic p;
        repeat ($urandom_range(200, 5)) @(negedge clk);
        hs(d, w, p);
        sb_q.push_back('{duty: d, check: 1'b0});
        sb_q.push_back('{duty: d, check: 1'b1});
        sb_q.push_back('{duty: d, check: 1'b1});
        cur_duty = d;
        repeat (3) wait_ps();
    endtask

    task automatic b2b(input logic [7:0] a, input logic [7:0] b);
        int w;
        logic p;
        repeat ($urandom_range(100, 5)) @(negedge clk);
        hs(a, w, p);
        sb_q.push_back('{duty: a, check: 1'b0});
        sb_q.push_back('{duty: b, check: 1'b0});
        sb_q.push_back('{duty: b, check: 1'b1});
        hs(b, w, p);
        chk("b2b_held_off", int'(w > 0), 1);
        chk("b2b_ready_at_wrap", int'(p), 1);
        cur_duty = b;
        repeat (2) wait_ps();
    endtask

    task automatic wrap_seg(input logic [7:0] d);
        int w;
        logic p;
        repeat (255) @(negedge clk);
        sb_q.push_back('{duty: cur_duty, check: 1'b1});
        sb_q.push_back('{duty: d, check: 1'b0});
        sb_q.push_back('{duty: d, check: 1'b1});
        hs(d, w, p);
        chk("wrap_capture_ready", w, 0);
        chk("wrap_capture_ps", int'(period_start), 1);
        cur_duty = d;
        repeat (2) wait_ps();
    endtask

    task automatic p4_run();
        int n, h, l;
        @(negedge clk);
        chk("p4_ready", int'(ready4), 1);
        duty4 = 8'd128;
        valid4 = 1'b1;
        @(negedge clk);
        valid4 = 1'b0;
        en4 = 1'b1;
        n = 0;
        while (!ps4 && n < 1100) begin
            @(negedge clk);
            n++;
        end
        chk("p4_first_ps_clks", n, 1024);
        repeat (2) begin
            n = 0;
            h = 0;
            l = 0;
            chk("p4_duty_active", int'(active4), 128);
            do begin
                h += int'(h4);
                l += int'(l4);
                n++;
                @(negedge clk);
            end while (!ps4 && n < 1100);
            chk("p4_period_clks", n, 1024);
            chk("p4_h_clks", h, (128 - DT) * 4);
            chk("p4_l_clks", l, (256 - 128 - DT) * 4);
        end
    endtask

    task automatic phase_main();
        seg(8'd64);
        seg(8'd0);
        seg(8'd1);
        seg(8'd255);
        seg(8'd254);
        seg(8'd3);
        seg(8'd253);
        b2b(8'd100, 8'd200);
        wrap_seg(8'($urandom_range(255, 0)));
        repeat (4) seg(8'($urandom_range(255, 0)));
    endtask

    task automatic phase_enable();
        int w, n;
        logic p;
        mon_on = 0;
        hs(8'd128, w, p);
        wait_ps();
        wait_ps();
        repeat (40) @(negedge clk);
        chk("en_high_before_drop", int'(pwm_h), 1);
        enable = 1'b0;
        @(negedge clk);
        chk("en_drop_h", int'(pwm_h), 0);
        chk("en_drop_l", int'(pwm_l), 0);
        hs(8'd50, w, p);
        chk("en_off_ready", w, 0);
        n = 0;
        repeat (20) begin
            @(negedge clk);
            n += int'(pwm_h | pwm_l | period_start);
        end
        chk("en_off_quiet", n, 0);
        chk("en_off_active", int'(duty_active), 128);
        enable = 1'b1;
        @(negedge clk);
        chk("reen_t1_low", int'(pwm_h | pwm_l), 0);
        @(negedge clk);
        chk("reen_t2_low", int'(pwm_h | pwm_l), 0);
        @(negedge clk);
        chk("reen_t3_high", int'(pwm_h), 1);
        n = 3;
        while (!period_start && n < 600) begin
            @(negedge clk);
            n++;
        end
        chk("reen_period_clks", n, 256);
        chk("reen_active", int'(duty_active), 50);
    endtask

    task automatic phase_reset();
        int w, n;
        logic p;
        hs(8'd200, w, p);
        n = 0;
        while (!pwm_h && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("rst_reach_high", int'(pwm_h), 1);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_async_h", int'(pwm_h), 0);
        chk("rst_async_l", int'(pwm_l), 0);
        chk("rst_async_ps", int'(period_start), 0);
        chk("rst_async_ready", int'(duty_ready), 1);
        chk("rst_async_active", int'(duty_active), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        while (!period_start && n < 600) begin
            @(negedge clk);
            n++;
        end
        chk("rst_restart_clks", n, 256);
        chk("rst_no_stale_pending", int'(duty_active), 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_h", int'(pwm_h), 0);
        chk("reset_l", int'(pwm_l), 0);
        chk("reset_ps", int'(period_start), 0);
        chk("reset_ready", int'(duty_ready), 1);
        chk("reset_active", int'(duty_active), 0);
        rst_n = 1'b1;
        @(negedge clk);
        mon_on = 1;
        enable = 1'b1;
        fork
            phase_main();
            p4_run();
        join
        phase_enable();
        phase_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
